// File: rtl/sfq_gate_sequencer_if.sv
// Purpose: operand request and result return channels of the SFQ gate sequencer.
// Latency: none, wires only.
// Backpressure: op channel is valid/ready toward the sequencer; rsp channel is valid/ready back to the host.
//
// Signals
//   op_valid/op_ready/op_data   host -> sequencer operand vector (N_IN lanes)
//   rsp_valid/rsp_ready         sequencer -> host result handshake
//   rsp_data                    1 = gate produced at least one output pulse in the window
//   rsp_err                     1 = gate produced two or more output pulses in the window
interface sfq_gate_sequencer_if #(
    parameter int N_IN = 2
);
    logic            op_valid;
    logic            op_ready;
    logic [N_IN-1:0] op_data;
    logic            rsp_valid;
    logic            rsp_ready;
    logic            rsp_data;
    logic            rsp_err;

    // Host / test sequencer side.
    modport master (
        output op_valid,
        output op_data,
        output rsp_ready,
        input  op_ready,
        input  rsp_valid,
        input  rsp_data,
        input  rsp_err
    );

    // Gate sequencer side.
    modport slave (
        input  op_valid,
        input  op_data,
        input  rsp_ready,
        output op_ready,
        output rsp_valid,
        output rsp_data,
        output rsp_err
    );
endinterface

// File: rtl/sfq_gate_sequencer.sv
// Purpose: sequences one evaluation of a clocked SFQ gate: data pulses, gate clock pulse, output observation.
// Latency: data_pulse cycle 1, gate_clk cycle 2+SETUP_CYC, rsp_valid cycle 3+SETUP_CYC+max(HOLD_CYC,OUT_WIN) after accept.
// Backpressure: one op in flight; op_ready only in IDLE; result held in RESP until rsp_ready.
//
// Ports
//   clkin       single clock, rising edge
//   rst_n       synchronous active-low reset (aborts any op in flight)
//   bus         op / rsp channels (slave side of sfq_gate_sequencer_if)
//   data_pulse  registered one-cycle pulses toward the gate data inputs
//   gate_clk    registered one-cycle pulse toward the gate clock input
//   gate_out    gate output, one cycle high per SFQ pulse
//   busy        high whenever the sequencer is not IDLE
module sfq_gate_sequencer #(
    parameter int N_IN      = 2,
    parameter int SETUP_CYC = 2,
    parameter int HOLD_CYC  = 2,
    parameter int OUT_WIN   = 4,
    parameter int CNT_W     = 8
) (
    input  logic                  clkin,
    input  logic                  rst_n,
    sfq_gate_sequencer_if.slave   bus,
    output logic [N_IN-1:0]       data_pulse,
    output logic                  gate_clk,
    input  logic                  gate_out,
    output logic                  busy
);

    // OBSERVE lasts long enough both to cover the output window and to honour
    // the gate's hold time before the next data pulse can be issued.
    localparam int OBS_CYC = (HOLD_CYC > OUT_WIN) ? HOLD_CYC : OUT_WIN;
    localparam int MAX_CYC = (SETUP_CYC > OBS_CYC) ? SETUP_CYC : OBS_CYC;
    localparam longint CNT_MAX = (longint'(1) << CNT_W) - 1;

    // The down-counter runs OBS_CYC..1 in OBSERVE; the window covers the
    // first OUT_WIN of those cycles, i.e. counter values above WIN_LO.
    localparam logic [CNT_W-1:0] OBS_LOAD   = CNT_W'(OBS_CYC);
    localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYC);
    localparam logic [CNT_W-1:0] WIN_LO     = CNT_W'(OBS_CYC - OUT_WIN);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    if (OUT_WIN < 1) begin : g_bad_out_win
        $error("sfq_gate_sequencer: OUT_WIN must be >= 1");
    end
    if (longint'(MAX_CYC) > CNT_MAX) begin : g_bad_cnt_w
        $error("sfq_gate_sequencer: CNT_W too narrow for SETUP_CYC/HOLD_CYC/OUT_WIN");
    end
    if (N_IN < 1) begin : g_bad_n_in
        $error("sfq_gate_sequencer: N_IN must be >= 1");
    end

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_DATA    = 3'd1,
        S_SETUP   = 3'd2,
        S_CLK     = 3'd3,
        S_OBSERVE = 3'd4,
        S_RESP    = 3'd5
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       pulse_cnt;
    logic [1:0]       pulse_cnt_nxt;
    logic             in_win;

    assign bus.op_ready = rst_n && (state == S_IDLE);
    assign busy         = (state != S_IDLE);

    // gate_out only counts inside the OBSERVE window; everywhere else it is
    // stray activity from the gate and must not leak into a result.
    assign in_win = (state == S_OBSERVE) && (cnt > WIN_LO);

    // Two-bit saturating pulse count: 0, 1 and "2 or more" are all the
    // result needs to distinguish.
    always_comb begin
        pulse_cnt_nxt = pulse_cnt;
        if (in_win && gate_out && (pulse_cnt != 2'b11)) begin
            pulse_cnt_nxt = pulse_cnt + 2'b01;
        end
    end

    always_ff @(posedge clkin) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            cnt           <= '0;
            pulse_cnt     <= '0;
            data_pulse    <= '0;
            gate_clk      <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_data  <= 1'b0;
            bus.rsp_err   <= 1'b0;
        end else begin
            // Pulse outputs are single-cycle: default low, raised only on
            // the transition into the state that owns them.
            data_pulse <= '0;
            gate_clk   <= 1'b0;

            case (state)
                S_IDLE: begin
                    // The data_pulse register doubles as the operand
                    // capture, so the pulse appears in the cycle after accept.
                    if (bus.op_valid) begin
                        data_pulse <= bus.op_data;
                        state      <= S_DATA;
                    end
                end

                S_DATA: begin
                    if (SETUP_CYC == 0) begin
                        gate_clk <= 1'b1;
                        state    <= S_CLK;
                    end else begin
                        cnt   <= SETUP_LOAD;
                        state <= S_SETUP;
                    end
                end

                S_SETUP: begin
                    if (cnt == CNT_ONE) begin
                        gate_clk <= 1'b1;
                        state    <= S_CLK;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end

                S_CLK: begin
                    cnt       <= OBS_LOAD;
                    pulse_cnt <= '0;
                    state     <= S_OBSERVE;
                end

                S_OBSERVE: begin
                    pulse_cnt <= pulse_cnt_nxt;
                    if (cnt == CNT_ONE) begin
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_data  <= (pulse_cnt_nxt != 2'b00);
                        bus.rsp_err   <= pulse_cnt_nxt[1];
                        state         <= S_RESP;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end

                S_RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        bus.rsp_data  <= 1'b0;
                        bus.rsp_err   <= 1'b0;
                        state         <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sfq_gate_sequencer.sv
// Purpose: self-checking bench for sfq_gate_sequencer (default build and a SETUP_CYC=0 build).
// Latency: expected response cycle/value pushed at op issue, popped when rsp_valid appears.
// Backpressure: exercises rsp_ready stalls, ignored op_valid while busy, back-to-back ops.
module tb_sfq_gate_sequencer;

    localparam int OUT_WIN_TB = 4;
    localparam int HOLD_TB    = 2;
    localparam int M_TB       = (HOLD_TB > OUT_WIN_TB) ? HOLD_TB : OUT_WIN_TB;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sel;
    logic       op_valid;
    logic [1:0] op_data;
    logic       rsp_ready;
    logic       gate_out;

    logic [1:0] dp0, dp1, dp;
    logic       gc0, gc1, gc;
    logic       bz0, bz1, bz;
    logic       go0, go1;
    logic       op_ready, rsp_valid, rsp_data, rsp_err;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic d;
        logic e;
        int   cyc;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        bit         s;
        logic [1:0] od;
        logic [15:0] mask;
        int         stall;
    } vec_t;
    vec_t vt[11];

    always #5 clk = ~clk;

    sfq_gate_sequencer_if #(.N_IN(2)) b0 ();
    sfq_gate_sequencer_if #(.N_IN(2)) b1 ();

    assign b0.op_valid  = op_valid && !sel;
    assign b1.op_valid  = op_valid && sel;
    assign b0.op_data   = op_data;
    assign b1.op_data   = op_data;
    assign b0.rsp_ready = rsp_ready;
    assign b1.rsp_ready = rsp_ready;
    assign go0          = gate_out && !sel;
    assign go1          = gate_out && sel;

    assign dp        = sel ? dp1 : dp0;
    assign gc        = sel ? gc1 : gc0;
    assign bz        = sel ? bz1 : bz0;
    assign op_ready  = sel ? b1.op_ready  : b0.op_ready;
    assign rsp_valid = sel ? b1.rsp_valid : b0.rsp_valid;
    assign rsp_data  = sel ? b1.rsp_data  : b0.rsp_data;
    assign rsp_err   = sel ? b1.rsp_err   : b0.rsp_err;

    sfq_gate_sequencer #(.N_IN(2), .SETUP_CYC(2), .HOLD_CYC(HOLD_TB), .OUT_WIN(OUT_WIN_TB), .CNT_W(8)) dut0 (
        .clkin      (clk),
        .rst_n      (rst_n),
        .bus        (b0),
        .data_pulse (dp0),
        .gate_clk   (gc0),
        .gate_out   (go0),
        .busy       (bz0)
    );

    sfq_gate_sequencer #(.N_IN(2), .SETUP_CYC(0), .HOLD_CYC(HOLD_TB), .OUT_WIN(OUT_WIN_TB), .CNT_W(8)) dut1 (
        .clkin      (clk),
        .rst_n      (rst_n),
        .bus        (b1),
        .data_pulse (dp1),
        .gate_clk   (gc1),
        .gate_out   (go1),
        .busy       (bz1)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Pulses counted in the output window: cycles 3+S .. 2+S+OUT_WIN after accept.
    function automatic int win_count(input logic [15:0] m, input int sc);
        int n = 0;
        for (int c = 3 + sc; c <= 2 + sc + OUT_WIN_TB; c++) begin
            if (m[c]) n++;
        end
        return n;
    endfunction

    task automatic run_op(input int idx, input bit s, input logic [1:0] od,
                          input logic [15:0] mask, input int stall);
        int   sc, k, dp_cnt, dp_cyc, gc_cnt, gc_cyc, rsp_cyc, unstable, rdy_busy, wait_cnt, n;
        logic [1:0] dp_val;
        logic r_d, r_e;
        bit   done;
        exp_t e;
        string tg;

        tg = $sformatf("op%0d", idx);
        sel = s;
        sc  = s ? 0 : 2;
        n   = win_count(mask, sc);
        e.d = (n != 0);
        e.e = (n >= 2);
        e.cyc = 3 + sc + M_TB;
        exp_q.push_back(e);

        @(negedge clk);
        check({tg, "_op_ready_idle"}, int'(op_ready), 1);
        check({tg, "_busy_idle"}, int'(bz), 0);
        op_valid  = 1'b1;
        op_data   = od;
        rsp_ready = (stall == 0);
        gate_out  = 1'b0;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        op_data  = ~od;
        gate_out = mask[1];

        k = 1; done = 0; dp_cnt = 0; dp_cyc = 0; dp_val = '0; gc_cnt = 0; gc_cyc = 0;
        rsp_cyc = 0; unstable = 0; rdy_busy = 0; wait_cnt = 0; r_d = 0; r_e = 0;
        while (!done && k < 40) begin
            @(negedge clk);
            if (dp != 2'b00) begin dp_cnt++; dp_cyc = k; dp_val = dp; end
            if (gc) begin gc_cnt++; gc_cyc = k; end
            if (op_ready) rdy_busy++;
            if (rsp_valid) begin
                if (rsp_cyc == 0) begin
                    rsp_cyc = k;
                    r_d = rsp_data;
                    r_e = rsp_err;
                    if (exp_q.size() == 0) begin
                        check({tg, "_unexpected_rsp"}, 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check({tg, "_rsp_cycle"}, rsp_cyc, e.cyc);
                        check({tg, "_rsp_data"}, int'(rsp_data), int'(e.d));
                        check({tg, "_rsp_err"}, int'(rsp_err), int'(e.e));
                    end
                end else if (rsp_data != r_d || rsp_err != r_e) begin
                    unstable++;
                end
                if (wait_cnt == stall) begin
                    rsp_ready = 1'b1;
                    op_valid  = 1'b0;
                    done      = 1;
                end else begin
                    // A competing request while the result is pending must be ignored.
                    op_valid = 1'b1;
                    op_data  = 2'b11;
                end
                wait_cnt++;
            end
            @(posedge clk);
            #1;
            k++;
            if (k < 16) gate_out = mask[k];
            else        gate_out = 1'b0;
        end
        gate_out = 1'b0;
        if (!done) check({tg, "_timeout"}, 0, 1);
        check({tg, "_dp_count"}, dp_cnt, (od != 2'b00) ? 1 : 0);
        if (od != 2'b00) begin
            check({tg, "_dp_cycle"}, dp_cyc, 1);
            check({tg, "_dp_value"}, int'(dp_val), int'(od));
        end
        check({tg, "_gclk_count"}, gc_cnt, 1);
        check({tg, "_gclk_cycle"}, gc_cyc, 2 + sc);
        check({tg, "_ready_while_busy"}, rdy_busy, 0);
        if (stall > 0) check({tg, "_rsp_unstable"}, unstable, 0);
    endtask

    task automatic run_abort();
        int gc_cnt, rv_cnt, dp_cnt;
        sel = 1'b0;
        @(negedge clk);
        check("abort_op_ready", int'(op_ready), 1);
        op_valid = 1'b1;
        op_data  = 2'b11;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        @(negedge clk);
        check("abort_dp_cycle1", int'(dp), 3);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_busy_after_rst", int'(bz), 0);
        check("abort_ready_in_rst", int'(op_ready), 0);
        check("abort_gclk_cycle3", int'(gc), 0);
        rst_n = 1'b1;
        gc_cnt = 0; rv_cnt = 0; dp_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (gc) gc_cnt++;
            if (rsp_valid) rv_cnt++;
            if (dp != 2'b00) dp_cnt++;
        end
        check("abort_gclk_count", gc_cnt, 0);
        check("abort_rsp_count", rv_cnt, 0);
        check("abort_dp_count", dp_cnt, 0);
        check("abort_ready_after", int'(op_ready), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // {sel, op_data, gate_out cycle mask, rsp_ready stall cycles}
        vt[0]  = '{1'b0, 2'b11, 16'h0040, 0};  // AND fires: gate_out cycle 6
        vt[1]  = '{1'b0, 2'b01, 16'h0000, 0};
        vt[2]  = '{1'b0, 2'b00, 16'h0000, 0};  // empty vector, gate still clocked
        vt[3]  = '{1'b0, 2'b10, 16'h00A0, 0};  // cycles 5 and 7 -> double pulse
        vt[4]  = '{1'b0, 2'b11, 16'h0008, 0};  // cycle 3, before window
        vt[5]  = '{1'b0, 2'b11, 16'h0200, 0};  // cycle 9, after window
        vt[6]  = '{1'b0, 2'b11, 16'h0100, 0};  // cycle 8, last window cycle
        vt[7]  = '{1'b0, 2'b11, 16'h0040, 5};  // stalled result
        vt[8]  = '{1'b0, 2'b01, 16'h00E0, 0};  // back-to-back, three pulses saturate
        vt[9]  = '{1'b1, 2'b11, 16'h0010, 0};  // SETUP_CYC=0: window 3..6
        vt[10] = '{1'b1, 2'b10, 16'h0084, 0};  // SETUP_CYC=0: clk cycle and resp cycle ignored

        sel       = 1'b0;
        rst_n     = 1'b0;
        op_valid  = 1'b1;
        op_data   = 2'b11;
        rsp_ready = 1'b1;
        gate_out  = 1'b0;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_dp", int'(dp), 0);
            check("rst_gclk", int'(gc), 0);
            check("rst_op_ready", int'(op_ready), 0);
            check("rst_rsp_valid", int'(rsp_valid), 0);
        end
        rst_n    = 1'b1;
        op_valid = 1'b0;
        @(negedge clk);
        check("post_rst_op_ready", int'(op_ready), 1);
        check("post_rst_busy", int'(bz), 0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 9; i++) begin
            run_op(i, vt[i].s, vt[i].od, vt[i].mask, vt[i].stall);
        end
        run_abort();
        @(posedge clk);
        #1;
        for (int i = 9; i < 11; i++) begin
            run_op(i, vt[i].s, vt[i].od, vt[i].mask, vt[i].stall);
        end
        @(negedge clk);
        check("final_op_ready", int'(op_ready), 1);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
